// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding, bubble word and the IF/ID record.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical bubble placed in IF/ID when it holds nothing
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load, increment enable and async reset.
module pc_reg #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc_plus4_o
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    // Load beats increment; the +4 wraps modulo 2^N with the carry dropped.
    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (en_i)
            pc_d = pc_plus4_o;
    end

    // PC state, forced to RESET_PC the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_plus4_o = pc_q + N'(4);
    assign pc_o       = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory
// address and captures the returned word into the IF/ID register.
module fetch_stage
    import core_pkg::*;
#(
    parameter int          N          = 32,
    parameter int          N_INSTR    = 32,
    parameter int          BYTE_WIDTH = 8,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter logic [N-1:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic [N-1:0] if_id_pc_plus4,
    output logic         if_id_valid,
    output logic         fetch_fault
);

    // Highest byte address at which a full word still fits in memory.
    localparam logic [N-1:0] LAST_WORD = N'(N_INSTR * BYTE_WIDTH - 4);

    fetch_state_t state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic         fault_q, fault_d;
    logic         pc_en;
    logic         pc_load;
    logic [N-1:0] pc_cur;
    logic [N-1:0] pc_plus4;
    logic         pc_bad;

    pc_reg #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .en_i       (pc_en),
        .load_i     (pc_load),
        .load_val_i (redirect_pc),
        .pc_o       (pc_cur),
        .pc_plus4_o (pc_plus4)
    );

    // A fetch is illegal when misaligned or when the word would run past memory.
    assign pc_bad = (pc_cur[1:0] != 2'b00) || (pc_cur > LAST_WORD);

    // Fetch FSM: redirect > stall > capture; a bad PC never samples imem_instr.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        if_id_d = if_id_q;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            BOOT: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
                fault_d       = pc_bad;
                state_d       = pc_bad ? FAULT : RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_load       = 1'b1;
                    if_id_d.instr = NOP_INSTR;
                    if_id_d.valid = 1'b0;
                end else if (stall) begin
                    if_id_d = if_id_q;
                end else if (!pc_bad) begin
                    pc_en            = 1'b1;
                    if_id_d.instr    = imem_instr;
                    if_id_d.pc       = pc_cur;
                    if_id_d.pc_plus4 = pc_plus4;
                    if_id_d.valid    = 1'b1;
                end else begin
                    if_id_d.instr = NOP_INSTR;
                    if_id_d.valid = 1'b0;
                    fault_d       = 1'b1;
                    state_d       = FAULT;
                end
            end
            FAULT: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
                if (redirect) begin
                    pc_load = 1'b1;
                    fault_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
                fault_d       = 1'b0;
                state_d       = BOOT;
            end
        endcase
    end

    // FSM, fault flag and IF/ID register; async reset restores the bubble at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= BOOT;
            fault_q          <= 1'b0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr      = pc_cur;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Address-tagged word; anything outside the 256-byte memory returns junk.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb begin
        imem_instr = (imem_addr < 32'd256) ? word_at(imem_addr) : JUNK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, 32'd1);
        check({tag, ".pc"}, if_id_pc, pc);
        check({tag, ".instr"}, if_id_instr, word_at(pc));
        check({tag, ".pc4"}, if_id_pc_plus4, pc + 32'd4);
        check({tag, ".addr"}, imem_addr, pc + 32'd4);
    endtask

    task automatic expect_bubble(input string tag, input logic [31:0] addr, input logic fault);
        check({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, ".instr"}, if_id_instr, NOP);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, fault});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        expect_bubble("rst", 32'h0, 1'b0);
        check("rst.pc", if_id_pc, 32'h0);
        check("rst.pc4", if_id_pc_plus4, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Boot cycle then sequential fetch
        tick(); expect_bubble("boot", 32'h0, 1'b0);
        tick(); expect_fetch("seq0", 32'h0);
        tick(); expect_fetch("seq4", 32'h4);

        // Stall holds PC and IF/ID
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.addr", imem_addr, 32'h8);
            check("stall.pc", if_id_pc, 32'h4);
            check("stall.valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        tick(); expect_fetch("seq8", 32'h8);
        tick(); expect_fetch("seqC", 32'hC);

        // Redirect beats a simultaneous stall
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick(); expect_bubble("redir", 32'h40, 1'b0);
        check("redir.pchold", if_id_pc, 32'hC);
        redirect = 1'b0; stall = 1'b0;
        tick(); expect_fetch("redir40", 32'h40);

        // Misaligned redirect target faults, stall ignored, redirect recovers
        redirect = 1'b1; redirect_pc = 32'h42;
        tick(); expect_bubble("mis.load", 32'h42, 1'b0);
        redirect = 1'b0;
        tick(); expect_bubble("mis.fault", 32'h42, 1'b1);
        stall = 1'b1;
        tick(); expect_bubble("mis.frozen", 32'h42, 1'b1);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
        tick(); expect_bubble("mis.clear", 32'h20, 1'b0);
        redirect = 1'b0;
        tick(); expect_fetch("mis20", 32'h20);

        // Top of memory: 252 is the last legal word, 256 faults
        redirect = 1'b1; redirect_pc = 32'hF8;
        tick(); expect_bubble("top.load", 32'hF8, 1'b0);
        redirect = 1'b0;
        tick(); expect_fetch("topF8", 32'hF8);
        tick(); expect_fetch("topFC", 32'hFC);
        tick(); expect_bubble("top.fault", 32'h100, 1'b1);
        check("top.pchold", if_id_pc, 32'hFC);
        tick(); expect_bubble("top.frozen", 32'h100, 1'b1);

        // Recover to 0, then async reset mid-cycle with a redirect in flight
        redirect = 1'b1; redirect_pc = 32'h0;
        tick(); expect_bubble("rec.load", 32'h0, 1'b0);
        redirect = 1'b0;
        tick(); expect_fetch("rec0", 32'h0);
        #3 rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        #1;
        expect_bubble("arst", 32'h0, 1'b0);
        check("arst.pc", if_id_pc, 32'h0);
        check("arst.pc4", if_id_pc_plus4, 32'h0);
        #2 rst = 1'b0; redirect = 1'b0;
        tick(); expect_bubble("reboot", 32'h0, 1'b0);
        tick(); expect_fetch("re0", 32'h0);
        tick(); expect_fetch("re4", 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard cap so the run always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete, expected completion before 20000");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
